// File: rtl/ppu_register_bank_if.sv
// ppu_register_bank_if: CPU register bus between the CPU bridge (master) and the PPU register bank (slave)
interface ppu_register_bank_if;
  logic       cpuSel;
  logic [2:0] cpuAddr;
  logic       readWrite;
  logic [7:0] cpuData_IN;
  logic [7:0] cpuData_OUT;
  modport master(output cpuSel, cpuAddr, readWrite, cpuData_IN, input cpuData_OUT);
  modport slave(input cpuSel, cpuAddr, readWrite, cpuData_IN, output cpuData_OUT);
endinterface

// File: rtl/ppu_register_bank.sv
// ppu_register_bank: PPU $2000-$2007 register front end with loopy scroll, buffered PPUDATA and palette; define PPU_OPEN_BUS_EN for the open-bus latch
module ppu_register_bank #(
  parameter int COLOUR_WIDTH   = 6,
  parameter int OAM_ADDR_WIDTH = 8,
  parameter int ACK_TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      reset_N,
  input  logic                      clkEn,
  ppu_register_bank_if.slave        cpuBus,
  output logic                      vramReq,
  output logic                      vramWe,
  output logic [13:0]               vramAddr,
  output logic [7:0]                vramWData,
  input  logic [7:0]                vramRData,
  input  logic                      vramAck,
  output logic [OAM_ADDR_WIDTH-1:0] oamAddress,
  output logic                      oamWe,
  output logic [7:0]                oamWData,
  input  logic [7:0]                oamRData,
  output logic [14:0]               videoRamAddress,
  output logic [2:0]                fineXScroll,
  output logic [7:0]                controlReg,
  output logic [7:0]                maskReg,
  input  logic                      incrementX,
  input  logic                      incrementY,
  input  logic                      resetX,
  input  logic                      resetY,
  input  logic                      setVerticalBlank,
  input  logic                      clearVerticalBlank,
  input  logic                      spriteOverflow,
  input  logic                      spriteCollision,
  input  logic [4:0]                palleteSelect,
  output logic [COLOUR_WIDTH-1:0]   selectedColour,
  output logic                      nmi_N,
  output logic                      dataBusy
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  state_t state;
  logic [CW-1:0] waitCnt;
  logic [COLOUR_WIDTH-1:0] palette [32];
  logic [14:0] v, t, vN, tN;
  logic [2:0] xN, a;
  logic w, wN, vblank, taken, accept, wr, rd, isPal, take2007, strobe;
  logic [7:0] d, readBuffer, readVal, rdHold, palOut, woVal;
  logic [4:0] statLow, palIdx;

  function automatic logic [4:0] palMirror(input logic [4:0] i);
    return (i[4] && i[1:0] == 2'b00) ? {1'b0, i[3:0]} : i;
  endfunction

  assign a = cpuBus.cpuAddr;
  assign d = cpuBus.cpuData_IN;
  assign accept = clkEn & cpuBus.cpuSel & ~taken;
  assign wr = accept & ~cpuBus.readWrite;
  assign rd = accept & cpuBus.readWrite;
  assign isPal = v[13:8] == 6'h3F;
  assign dataBusy = state != IDLE;
  assign take2007 = accept && a == 3'd7 && !dataBusy;
  assign strobe = incrementX | incrementY | resetX | resetY;
  assign palIdx = palMirror(v[4:0]);
  assign palOut = 8'(palette[palIdx]);
  assign nmi_N = ~(vblank & controlReg[7]);
  assign oamWe = wr && a == 3'd4;
  assign oamWData = d;
  assign videoRamAddress = v;
  assign readVal = a == 3'd2 ? {vblank, spriteCollision, spriteOverflow, statLow} :
                   a == 3'd4 ? oamRData :
                   a == 3'd7 ? ((isPal && !dataBusy) ? palOut : readBuffer) : woVal;
  // read data is live on the accepting cycle, then held so side effects cannot disturb it
  assign cpuBus.cpuData_OUT = (cpuBus.cpuSel & cpuBus.readWrite) ? (rd ? readVal : rdHold) : 8'h00;

`ifdef PPU_OPEN_BUS_EN
  logic [7:0] openBus;
  logic [19:0] decayCnt;
  assign woVal = openBus;
  assign statLow = openBus[4:0];
  // open-bus latch refreshed by every bus transfer, decaying to 0 after 2^20 idle clkEn cycles
  always_ff @(posedge clk or negedge reset_N)
    if (!reset_N) begin
      openBus <= 8'h00;
      decayCnt <= '0;
    end else if (clkEn) begin
      openBus <= wr ? d : rd ? readVal : (&decayCnt) ? 8'h00 : openBus;
      decayCnt <= (wr | rd) ? '0 : decayCnt + 20'd1;
    end
`else
  assign woVal = 8'h00;
  assign statLow = 5'h00;
`endif

  // loopy t/x/w and v: CPU register effects first, then render strobes layered on top
  always_comb begin
    tN = t;
    xN = fineXScroll;
    wN = w;
    vN = v;
    if (wr && a == 3'd0) tN[11:10] = d[1:0];
    if (wr && a == 3'd5) begin
      if (!w) begin
        tN[4:0] = d[7:3];
        xN = d[2:0];
      end else begin
        tN[9:5] = d[7:3];
        tN[14:12] = d[2:0];
      end
      wN = ~w;
    end
    if (wr && a == 3'd6) begin
      if (!w) tN[14:8] = {1'b0, d[5:0]};
      else begin
        tN[7:0] = d;
        vN = tN;
      end
      wN = ~w;
    end
    if (rd && a == 3'd2) wN = 1'b0;
    if (take2007 && !strobe) vN = vN + (controlReg[2] ? 15'd32 : 15'd1);
    if (incrementX) {vN[10], vN[4:0]} = {vN[10], vN[4:0]} + 6'd1;
    if (incrementY) begin
      if (vN[14:12] != 3'd7) vN[14:12] = vN[14:12] + 3'd1;
      else begin
        vN[14:12] = 3'd0;
        vN[11] = vN[9:5] == 5'd29 ? ~vN[11] : vN[11];
        vN[9:5] = vN[9:5] == 5'd29 ? 5'd0 : vN[9:5] + 5'd1;
      end
    end
    if (resetX) {vN[10], vN[4:0]} = {tN[10], tN[4:0]};
    if (resetY) {vN[14:11], vN[9:5]} = {tN[14:11], tN[9:5]};
  end

  // register file, vblank flag, strobe edge tracking and render colour lookup
  always_ff @(posedge clk or negedge reset_N)
    if (!reset_N) begin
      taken <= 1'b0;
      v <= '0;
      t <= '0;
      fineXScroll <= '0;
      w <= 1'b0;
      controlReg <= '0;
      maskReg <= '0;
      oamAddress <= '0;
      vblank <= 1'b0;
      rdHold <= '0;
      selectedColour <= '0;
    end else if (clkEn) begin
      taken <= cpuBus.cpuSel;
      v <= vN;
      t <= tN;
      fineXScroll <= xN;
      w <= wN;
      if (wr && a == 3'd0) controlReg <= d;
      if (wr && a == 3'd1) maskReg <= d;
      if (wr && a == 3'd3) oamAddress <= OAM_ADDR_WIDTH'(d);
      if (wr && a == 3'd4) oamAddress <= oamAddress + OAM_ADDR_WIDTH'(1);
      vblank <= (rd && a == 3'd2) ? 1'b0 : setVerticalBlank ? 1'b1 : clearVerticalBlank ? 1'b0 : vblank;
      if (rd) rdHold <= readVal;
      selectedColour <= palette[palleteSelect[1:0] == 2'b00 ? 5'd0 : palleteSelect] &
                        (maskReg[0] ? COLOUR_WIDTH'(8'h30) : {COLOUR_WIDTH{1'b1}});
    end

  // palette RAM written directly by CPU writes in the $3F00 window
  always_ff @(posedge clk or negedge reset_N)
    if (!reset_N) for (int i = 0; i < 32; i++) palette[i] <= '0;
    else if (take2007 && !cpuBus.readWrite && isPal) palette[palIdx] <= d[COLOUR_WIDTH-1:0];

  // PPUDATA VRAM handshake FSM with ack timeout; palette reads refill the buffer from the mirrored nametable
  always_ff @(posedge clk or negedge reset_N)
    if (!reset_N) begin
      state <= IDLE;
      vramReq <= 1'b0;
      vramWe <= 1'b0;
      vramAddr <= '0;
      vramWData <= '0;
      readBuffer <= '0;
      waitCnt <= '0;
    end else if (clkEn) begin
      if (state == IDLE) begin
        if (take2007 && (cpuBus.readWrite || !isPal)) begin
          state <= cpuBus.readWrite ? RD_WAIT : WR_WAIT;
          vramReq <= 1'b1;
          vramWe <= ~cpuBus.readWrite;
          vramAddr <= isPal ? v[13:0] & 14'h2FFF : v[13:0];
          vramWData <= d;
          waitCnt <= '0;
        end
      end else if (vramAck || waitCnt == CW'(ACK_TIMEOUT - 1)) begin
        state <= IDLE;
        vramReq <= 1'b0;
        vramWe <= 1'b0;
        if (vramAck && state == RD_WAIT) readBuffer <= vramRData;
      end else waitCnt <= waitCnt + CW'(1);
    end
endmodule
